// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive front-end for the debug/user UART. It oversamples the serial line at
// 4x using a per-quarter-bit clock divider and recovers 8N1 frames by a 3-sample
// majority vote. Received bytes go into a first-word-fall-through FIFO, which
// presents them as a valid/ready byte stream.
//
// Parameters:
//   CLK_DIV    clk cycles per quarter bit (>= 2); one bit time is 4*CLK_DIV.
//   FIFO_DEPTH byte entries (power of two, >= 2).
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   i_uart_rx    serial line, idle high, asynchronous to clk
//   o_data       FIFO head byte, meaningful only while o_valid=1 (0 when empty)
//   o_valid      FIFO non-empty
//   i_ready      consumer takes the head byte this cycle
//   o_count      current FIFO occupancy
//   o_frame_err  one-cycle pulse: stop bit sampled as 0
//   o_overflow   one-cycle pulse: received byte dropped, FIFO full
module uart_rx_fifo #(
  parameter int CLK_DIV    = 108,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_uart_rx,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_frame_err,
  output logic                          o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // Receiver state
  logic          sync1_q;
  logic          rxs_q;       // synchronized line
  logic          rxs_prev_q;  // rxs one cycle earlier, for falling-edge detect
  state_t        state_q;
  logic [DW-1:0] div_q;       // cycle within the current quarter
  logic [1:0]    qtr_q;       // quarter within the current bit
  logic [3:0]    bit_q;       // 0 = start, 1..8 = data, 9 = stop
  logic [1:0]    smp_q;       // first two samples of the current bit
  logic [7:0]    shift_q;
  logic          frame_err_q;

  // FIFO state
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  // Decode
  logic tick;
  logic decide;
  logic bit_val;
  logic push_req;
  logic frame_bad;
  logic full;
  logic pop;
  logic do_push;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    tick      = 1'b0;
    decide    = 1'b0;
    bit_val   = 1'b0;
    push_req  = 1'b0;
    frame_bad = 1'b0;
    tick      = (div_q == DW'(CLK_DIV - 1));
    // The third sample is the current rxs; the vote is taken in that cycle.
    bit_val   = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
    decide    = tick && (qtr_q == 2'd2) &&
                (state_q == S_START || state_q == S_DATA || state_q == S_STOP);
    push_req  = decide && (state_q == S_STOP) && bit_val;
    frame_bad = decide && (state_q == S_STOP) && !bit_val;
  end

  assign o_valid = (count_q != '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = o_valid && i_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_req && (!full || pop);

  // Two-flop synchronizer plus the delayed copy used for edge detection.
  // All three reset to the idle level so reset release cannot look like a start.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= i_uart_rx;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Frame FSM. Counters are cleared at the detection cycle T so the first
  // sample of bit k lands on T+4kD+D, then T+4kD+2D and T+4kD+3D.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      qtr_q       <= '0;
      bit_q       <= '0;
      smp_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_bad;
      case (state_q)
        S_IDLE: begin
          if (rxs_prev_q && !rxs_q) begin
            div_q   <= '0;
            qtr_q   <= '0;
            bit_q   <= '0;
            smp_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START, S_DATA, S_STOP: begin
          if (tick) begin
            div_q <= '0;
            qtr_q <= qtr_q + 2'd1;
            if (qtr_q == 2'd3) bit_q <= bit_q + 4'd1;
            if (qtr_q == 2'd0) smp_q[0] <= rxs_q;
            if (qtr_q == 2'd1) smp_q[1] <= rxs_q;
          end else begin
            div_q <= div_q + DW'(1);
          end
          if (decide) begin
            case (state_q)
              S_START: state_q <= bit_val ? S_IDLE : S_DATA;
              S_DATA: begin
                shift_q <= {bit_val, shift_q[7:1]};
                if (bit_q == 4'd8) state_q <= S_STOP;
              end
              default: state_q <= bit_val ? S_IDLE : S_WAIT_IDLE;
            endcase
          end
        end
        S_WAIT_IDLE: begin
          // Hold off while the line stays low (break) to avoid re-triggering.
          if (rxs_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_req && full && !pop;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define what
  // is valid, and o_data is forced to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= shift_q;
  end

  assign o_data      = o_valid ? mem[rd_ptr_q] : 8'h00;
  assign o_count     = count_q;
  assign o_frame_err = frame_err_q;
  assign o_overflow  = overflow_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive front-end for the shared debug/user UART. It oversamples the serial input at 4x using a per-quarter-bit clock divider and recovers 8N1 frames by majority vote. Received bytes are buffered in a first-word-fall-through FIFO and presented to the UART command/bus logic through a valid/ready byte stream. It sits between the board RX pin and the ISP/user-UART byte consumer.

## Interface
- CLK_DIV, default 108: clk cycles per quarter bit; one bit time is 4*CLK_DIV cycles (50 MHz / 4 / 115200). Legal range is ≥2.
- FIFO_DEPTH, default 8: byte entries; must be a power of two and ≥2.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- i_uart_rx  in  1  serial line; idle is 1; not synchronous to clk.
- o_data  out  8  FIFO head byte; valid only while o_valid=1.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  consumer accepts the head byte this cycle.
- o_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- o_overflow  out  1  one-cycle pulse: byte dropped because the FIFO was full.

## Operation
- Synchronizer: 2 flip-flops on i_uart_rx, both reset to 1. Call the output rxs; its previous value is rxs_d.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on the cycle where rxs_d=1 and rxs=0 (the detection cycle T), clear the divider and the sample registers and go to START.
- Bit k has k=0 for start, k=1..8 for data LSB first, and k=9 for stop. Bit k spans cycles T+4kD .. T+4kD+4D-1, where D=CLK_DIV.
- Within bit k, rxs is sampled at T+4kD+D, T+4kD+2D and T+4kD+3D. The bit value is the majority of the 3 samples, decided at the third sample.
- START: if the majority is 1, treat it as a false start; go to IDLE with no output. If 0, go to DATA.
- DATA: shift each decided bit in LSB-first. After bit 8, go to STOP.
- STOP, majority 1: push the byte and go to IDLE.
- STOP, majority 0: pulse o_frame_err, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs=1, then go to IDLE. This prevents re-triggering on a break.
- FIFO is a circular buffer with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH. The occupancy counter is one bit wider.
- Pop occurs when o_valid && i_ready. Push occurs on a valid stop bit.
- Push while full with no pop in the same cycle: drop the byte, pulse o_overflow, leave FIFO contents unchanged.
- Push and pop in the same cycle when full: both are accepted and the count stays at DEPTH.
- Push and pop in the same cycle when empty: the push is stored, the pop is ignored (o_valid was 0), and count becomes 1.
- i_ready while empty has no effect.

## Timing
- Reset values: o_data=0, o_valid=0, o_count=0, o_frame_err=0, o_overflow=0. State is IDLE and both pointers are 0.
- Reset asserted mid-frame: the partial byte is lost and FIFO contents are cleared. After release, the block waits for a new falling edge.
- Pin-to-detection: 3 cycles, from the pin edge through 2 sync flops plus the edge compare.
- Stop decision is at T+39D. The push is registered, so with the FIFO previously empty, o_valid=1 and o_data are valid from cycle T+39D+1.
- o_frame_err and o_overflow are asserted in cycle T+39D+1 for exactly 1 cycle.
- Return to IDLE occurs at T+39D+1. This leaves D-1 cycles of stop-bit margin before the earliest next start edge.
- FWFT read: o_data changes in the cycle after a pop. o_valid falls in the cycle after the last pop.
- o_count updates 1 cycle after the push/pop event.
- Tolerance: a single-quarter glitch within any bit is outvoted.

## Test plan
- Test parameters are D=4 (16 clk per bit) and DEPTH=4. Each test starts from reset released and an idle line.
- Single byte: send 0xA5 with a valid stop bit. Required: o_valid rises at T+157, o_data=0xA5, o_count=1. Pulsing i_ready for 1 cycle gives o_valid=0 and o_count=0.
- False start / glitch: drive the line low for 6 cycles, then high. Required: no o_valid and no o_frame_err; a following 0x3C is received correctly.
- Majority: send 0x00 with rxs forced to 1 for quarter 2 of bit 3. Required: o_data=0x00.
- Frame error: send 0x5A with stop=0, hold the line low for 40 cycles, then idle, then send 0x11. Required: exactly one o_frame_err pulse, no 0x5A in the FIFO, 0x11 received.
- Overflow and full push/pop:
  - With i_ready=0, send 0x01..0x05. Required: o_count=4, one o_overflow pulse at the 5th stop, drain yields 01,02,03,04.
  - Refill to 4, then assert i_ready for exactly the push cycle of 0x06. Required: no overflow and o_count stays 4.
- Reset mid-frame: assert rst during bit 4 of 0x77. Required: all outputs 0 immediately; after release, a following 0x42 is received as the only byte.
